anton_neopixel_registers_multi: RTL and testbench

- Next-generation bus-side register file and pixel store for the NeoPixel controller.
- Serves CHANNELS independent output channels, each with its own MAX/CTRL registers, from one double-buffered pixel memory.
- Adds a hardware clear (init) sequencer, a frame-synchronous bank swap, and maskable interrupt flags.
- Sits between the byte bus (APB bridge) and the per-channel stream/timing engines.

---
 rtl/anton_neopixel_registers_multi.sv | 267 ++++++++++++++++++++++++++
 tb/tb_anton_neopixel_registers_multi.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/anton_neopixel_registers_multi.sv
// Bus-side register file and double-buffered pixel store for a
// multi-channel NeoPixel controller, with clear sequencer, frame swap
// and maskable interrupt flags.
// Ports:
//   busClk, busReset        clock, async active-high reset
//   busAddr/busDataIn       byte bus address and write data
//   busWrite/busRead        one-cycle access strobes
//   busDataOut              registered read data
//   irq                     OR of enabled interrupt flags
//   streamAddr/streamData   stream-side front-bank read port
//   syncStart/streamSyncOf  per-channel frame start / end pulses
//   state                   per-channel engine state (read-only)
//   regMax, regCtrl*        per-channel configuration outputs
//   initBusy                clear sequencer active
module anton_neopixel_registers_multi #(
   parameter int BUFFER_END = 63,
   parameter int CHANNELS = 2,
   localparam int BUFFER_BITS = $clog2(BUFFER_END + 1),
   localparam int CH_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                     busClk,
   input  logic                     busReset,
   input  logic [13:0]              busAddr,
   input  logic [7:0]               busDataIn,
   input  logic                     busWrite,
   input  logic                     busRead,
   output logic [7:0]               busDataOut,
   output logic                     irq,
   input  logic [BUFFER_BITS-1:0]   streamAddr,
   output logic [7:0]               streamData,
   input  logic [CHANNELS-1:0]      syncStart,
   input  logic [CHANNELS-1:0]      streamSyncOf,
   input  logic [CHANNELS-1:0]      state,
   output logic [13*CHANNELS-1:0]   regMax,
   output logic [CHANNELS-1:0]      regCtrlLimit,
   output logic [CHANNELS-1:0]      regCtrlRun,
   output logic [CHANNELS-1:0]      regCtrlLoop,
   output logic [CHANNELS-1:0]      regCtrl32bit,
   output logic                     initBusy
);

   localparam int FLAG_W = CHANNELS + 1;
   localparam logic [BUFFER_BITS-1:0] LAST_IDX = BUFFER_BITS'(BUFFER_END);
   localparam logic [BUFFER_BITS:0] LAST_EXT = (BUFFER_BITS + 1)'(BUFFER_END);
   localparam logic [CH_BITS:0] CH_LIMIT = (CH_BITS + 1)'(CHANNELS);

   typedef enum logic {IDLE, CLEAR} initState_t;

   initState_t initState;
   logic [BUFFER_BITS-1:0] clearCnt;
   logic frontBank;
   logic swapPending;
   logic [FLAG_W-1:0] irqFlags;
   logic [FLAG_W-1:0] irqEn;
   logic [12:0] maxReg [CHANNELS];

   // Bank 0 is the front bank when frontBank is 0.
   logic [7:0] bank0 [0:BUFFER_END];
   logic [7:0] bank1 [0:BUFFER_END];

   logic isPixel, isChan, isGlob;
   logic [BUFFER_BITS-1:0] pixIdx;
   logic pixInRange, streamInRange, clearing;
   logic [CH_BITS-1:0] chSel;
   logic chValid;
   logic [2:0] chReg;
   logic [1:0] gReg;
   logic pixWr, cfgWr, gctrlWr, flagWr, enWr;
   logic startInit, swapReq, clearLast;
   logic pendNext, swapGo;
   logic [15:0] busWide, flagsWide, enWide;
   logic [FLAG_W-1:0] flagData, flagSet;
   logic [7:0] rdData;
   logic unusedBits;

   assign isPixel = ~busAddr[13];
   assign isChan = busAddr[13] & ~busAddr[12];
   assign isGlob = busAddr[13] & busAddr[12];
   assign pixIdx = busAddr[BUFFER_BITS-1:0];
   assign pixInRange = ({1'b0, pixIdx} <= LAST_EXT);
   assign streamInRange = ({1'b0, streamAddr} <= LAST_EXT);
   assign chSel = busAddr[3 +: CH_BITS];
   assign chValid = ({1'b0, chSel} < CH_LIMIT);
   assign chReg = busAddr[2:0];
   assign gReg = busAddr[1:0];
   assign clearing = (initState == CLEAR);
   assign unusedBits = ^busAddr;

   assign pixWr = busWrite & isPixel & pixInRange & ~clearing;
   // MAX/CTRL are frozen while the clear sequencer runs.
   assign cfgWr = busWrite & isChan & chValid & ~clearing;
   assign gctrlWr = busWrite & isGlob & (gReg == 2'd0);
   assign flagWr = busWrite & isGlob & (gReg == 2'd2);
   assign enWr = busWrite & isGlob & (gReg == 2'd3);

   assign startInit = gctrlWr & busDataIn[0] & ~clearing;
   assign swapReq = gctrlWr & busDataIn[1];
   assign clearLast = clearing & (clearCnt == LAST_IDX);

   // A swap fires on the request cycle itself when nothing is running,
   // and is held off while a clear is running or being started.
   assign pendNext = swapPending | swapReq;
   assign swapGo = pendNext & ~clearing & ~startInit
                 & (streamSyncOf[0] | ~|regCtrlRun);

   assign busWide = {8'h00, busDataIn};
   assign flagData = busWide[FLAG_W-1:0];
   assign flagSet = {streamSyncOf, clearLast};
   assign flagsWide = 16'(irqFlags);
   assign enWide = 16'(irqEn);

   assign irq = |(irqFlags & irqEn);

   for (genvar g = 0; g < CHANNELS; g++) begin : gMax
      assign regMax[13*g +: 13] = maxReg[g];
   end

   always_comb begin
      rdData = 8'h00;
      unique case (1'b1)
         isPixel: begin
            if (pixInRange && !clearing)
               rdData = frontBank ? bank0[pixIdx] : bank1[pixIdx];
         end
         isChan: begin
            if (chValid) begin
               case (chReg)
                  3'd0: rdData = maxReg[chSel][7:0];
                  3'd1: rdData = {3'b000, maxReg[chSel][12:8]};
                  3'd2: rdData = {4'h0, regCtrl32bit[chSel],
                                  regCtrlLoop[chSel], regCtrlRun[chSel],
                                  regCtrlLimit[chSel]};
                  3'd3: rdData = {7'h00, state[chSel]};
                  default: rdData = 8'h00;
               endcase
            end
         end
         isGlob: begin
            case (gReg)
               2'd1: rdData = {6'h00, swapPending, initBusy};
               2'd2: rdData = flagsWide[7:0];
               2'd3: rdData = enWide[7:0];
               default: rdData = 8'h00;
            endcase
         end
         default: rdData = 8'h00;
      endcase
   end

   always_ff @(posedge busClk or posedge busReset) begin
      if (busReset) begin
         initState <= IDLE;
         clearCnt <= '0;
         initBusy <= 1'b0;
      end else begin
         unique case (initState)
            IDLE: begin
               if (startInit) begin
                  initState <= CLEAR;
                  clearCnt <= '0;
                  initBusy <= 1'b1;
               end
            end
            CLEAR: begin
               if (clearCnt == LAST_IDX) begin
                  initState <= IDLE;
                  clearCnt <= '0;
                  initBusy <= 1'b0;
               end else begin
                  clearCnt <= clearCnt + 1'b1;
               end
            end
            default: initState <= IDLE;
         endcase
      end
   end

   always_ff @(posedge busClk or posedge busReset) begin
      if (busReset) begin
         frontBank <= 1'b0;
         swapPending <= 1'b0;
      end else if (swapGo) begin
         frontBank <= ~frontBank;
         swapPending <= 1'b0;
      end else begin
         swapPending <= pendNext;
      end
   end

   always_ff @(posedge busClk or posedge busReset) begin
      if (busReset) begin
         irqFlags <= '0;
         irqEn <= '0;
      end else begin
         // Hardware set wins over a same-cycle write-one-to-clear.
         irqFlags <= (irqFlags & ~(flagWr ? flagData : '0)) | flagSet;
         if (enWr)
            irqEn <= flagData;
      end
   end

   always_ff @(posedge busClk or posedge busReset) begin
      if (busReset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            maxReg[i] <= '0;
            regCtrlLimit[i] <= 1'b0;
            regCtrlRun[i] <= 1'b0;
            regCtrlLoop[i] <= 1'b0;
            regCtrl32bit[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (startInit) begin
               maxReg[i] <= '0;
               regCtrlLimit[i] <= 1'b0;
               regCtrlRun[i] <= 1'b0;
               regCtrlLoop[i] <= 1'b0;
               regCtrl32bit[i] <= 1'b0;
            end else begin
               if (cfgWr && chSel == CH_BITS'(i) && chReg == 3'd0)
                  maxReg[i][7:0] <= busDataIn;
               if (cfgWr && chSel == CH_BITS'(i) && chReg == 3'd1)
                  maxReg[i][12:8] <= busDataIn[4:0];
               if (cfgWr && chSel == CH_BITS'(i) && chReg == 3'd2) begin
                  regCtrlLimit[i] <= busDataIn[0];
                  regCtrlRun[i] <= busDataIn[1];
                  regCtrlLoop[i] <= busDataIn[2];
                  regCtrl32bit[i] <= busDataIn[3];
               end else if (syncStart[i]) begin
                  regCtrlRun[i] <= 1'b1;
               end else if (streamSyncOf[i]) begin
                  regCtrlRun[i] <= regCtrlLoop[i];
               end
            end
         end
      end
   end

   always_ff @(posedge busClk or posedge busReset) begin
      if (busReset) begin
         busDataOut <= 8'h00;
         streamData <= 8'h00;
      end else begin
         if (busRead)
            busDataOut <= rdData;
         if (streamInRange)
            streamData <= frontBank ? bank1[streamAddr]
                                    : bank0[streamAddr];
         else
            streamData <= 8'h00;
      end
   end

   // Pixel storage is deliberately not reset.
   always_ff @(posedge busClk) begin
      if (clearing) begin
         bank0[clearCnt] <= 8'h00;
         bank1[clearCnt] <= 8'h00;
      end else if (pixWr) begin
         if (frontBank)
            bank0[pixIdx] <= busDataIn;
         else
            bank1[pixIdx] <= busDataIn;
      end
   end

endmodule

// File: tb/tb_anton_neopixel_registers_multi.sv
// Self-checking bench for anton_neopixel_registers_multi: directed
// scenarios plus random traffic against a behavioural model.
module tb_anton_neopixel_registers_multi;
  localparam int BE = 63;
  localparam int CH = 2;

  logic busClk = 1'b0;
  logic busReset;
  logic [13:0] busAddr;
  logic [7:0] busDataIn;
  logic busWrite, busRead;
  logic [7:0] busDataOut;
  logic irq;
  logic [5:0] streamAddr;
  logic [7:0] streamData;
  logic [CH-1:0] syncStart, streamSyncOf, state;
  logic [13*CH-1:0] regMax;
  logic [CH-1:0] regCtrlLimit, regCtrlRun, regCtrlLoop, regCtrl32bit;
  logic initBusy;

  anton_neopixel_registers_multi #(.BUFFER_END(BE), .CHANNELS(CH)) dut (
    .busClk(busClk), .busReset(busReset), .busAddr(busAddr),
    .busDataIn(busDataIn), .busWrite(busWrite), .busRead(busRead),
    .busDataOut(busDataOut), .irq(irq), .streamAddr(streamAddr),
    .streamData(streamData), .syncStart(syncStart),
    .streamSyncOf(streamSyncOf), .state(state), .regMax(regMax),
    .regCtrlLimit(regCtrlLimit), .regCtrlRun(regCtrlRun),
    .regCtrlLoop(regCtrlLoop), .regCtrl32bit(regCtrl32bit),
    .initBusy(initBusy));

  always #5 busClk = ~busClk;

  localparam logic [13:0] GCTRL = 14'h3000;
  localparam logic [13:0] STATUS = 14'h3001;
  localparam logic [13:0] FLAGS = 14'h3002;
  localparam logic [13:0] IEN = 14'h3003;

  logic [7:0] mb [2][64];
  bit mk [2][64];
  int mFront, mCnt;
  bit mPend, mClear;
  logic [12:0] mMax [CH];
  bit [CH-1:0] mLim, mRun, mLoop, m32;
  bit [CH:0] mFlag, mEn;
  logic [7:0] mOut, mStream;
  bit mOutK, mStreamK;
  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mFront = 0; mCnt = 0; mPend = 0; mClear = 0;
    for (int c = 0; c < CH; c++) mMax[c] = '0;
    mLim = '0; mRun = '0; mLoop = '0; m32 = '0;
    mFlag = '0; mEn = '0;
    mOut = 8'h00; mOutK = 1; mStream = 8'h00; mStreamK = 1;
  endtask

  task automatic bus_view(input logic [13:0] a,
                          output logic [7:0] v, output bit k);
    int idx, c;
    v = 8'h00; k = 1;
    idx = int'(a[5:0]);
    c = int'(a[3]);
    if (!a[13]) begin
      if (!mClear && idx <= BE) begin
        v = mb[1-mFront][idx]; k = mk[1-mFront][idx];
      end
    end else if (!a[12]) begin
      case (a[2:0])
        3'd0: v = mMax[c][7:0];
        3'd1: v = {3'b000, mMax[c][12:8]};
        3'd2: v = {4'h0, m32[c], mLoop[c], mRun[c], mLim[c]};
        3'd3: v = {7'h00, state[c]};
        default: v = 8'h00;
      endcase
    end else begin
      case (a[1:0])
        2'd1: v = {6'h00, mPend, mClear};
        2'd2: v = 8'(mFlag);
        2'd3: v = 8'(mEn);
        default: v = 8'h00;
      endcase
    end
  endtask

  task automatic model_edge();
    logic [7:0] rv;
    bit rk, gw, startInit, swapReq, clearLast, pend, cw;
    int idx;
    if (busRead) begin
      bus_view(busAddr, rv, rk); mOut = rv; mOutK = rk;
    end
    mStream = mb[mFront][streamAddr];
    mStreamK = mk[mFront][streamAddr];
    gw = busWrite && busAddr[13] && busAddr[12];
    startInit = gw && busAddr[1:0] == 2'd0 && busDataIn[0] && !mClear;
    swapReq = gw && busAddr[1:0] == 2'd0 && busDataIn[1];
    clearLast = mClear && mCnt == BE;
    if (mClear) begin
      for (int b = 0; b < 2; b++) begin
        mb[b][mCnt] = 8'h00; mk[b][mCnt] = 1;
      end
    end else if (busWrite && !busAddr[13]) begin
      idx = int'(busAddr[5:0]);
      mb[1-mFront][idx] = busDataIn; mk[1-mFront][idx] = 1;
    end
    pend = mPend || swapReq;
    if (pend && !mClear && !startInit &&
        (streamSyncOf[0] || mRun == 0)) begin
      mFront = 1 - mFront; mPend = 0;
    end else mPend = pend;
    if (gw && busAddr[1:0] == 2'd2) mFlag &= ~busDataIn[CH:0];
    mFlag |= {streamSyncOf, clearLast};
    if (gw && busAddr[1:0] == 2'd3) mEn = busDataIn[CH:0];
    for (int c = 0; c < CH; c++) begin
      cw = busWrite && busAddr[13] && !busAddr[12] &&
           int'(busAddr[3]) == c && !mClear;
      if (startInit) begin
        mMax[c] = '0; mLim[c] = 0; mRun[c] = 0; mLoop[c] = 0; m32[c] = 0;
      end else begin
        if (cw && busAddr[2:0] == 3'd0) mMax[c][7:0] = busDataIn;
        if (cw && busAddr[2:0] == 3'd1) mMax[c][12:8] = busDataIn[4:0];
        if (cw && busAddr[2:0] == 3'd2) begin
          mLim[c] = busDataIn[0]; mRun[c] = busDataIn[1];
          mLoop[c] = busDataIn[2]; m32[c] = busDataIn[3];
        end else if (syncStart[c]) mRun[c] = 1;
        else if (streamSyncOf[c]) mRun[c] = mLoop[c];
      end
    end
    if (startInit) begin
      mClear = 1; mCnt = 0;
    end else if (mClear) begin
      if (mCnt == BE) mClear = 0; else mCnt++;
    end
  endtask

  task automatic check_all();
    logic [13*CH-1:0] em;
    for (int c = 0; c < CH; c++) em[13*c +: 13] = mMax[c];
    if (mOutK) chk("busDataOut", busDataOut, mOut);
    if (mStreamK) chk("streamData", streamData, mStream);
    chk("initBusy", initBusy, mClear);
    chk("irq", irq, |(mFlag & mEn));
    chk("regCtrlRun", regCtrlRun, mRun);
    chk("regCtrlLoop", regCtrlLoop, mLoop);
    chk("regCtrlLimit", regCtrlLimit, mLim);
    chk("regCtrl32bit", regCtrl32bit, m32);
    chk("regMax", regMax, em);
  endtask

  task automatic tick();
    model_edge();
    @(posedge busClk);
    #1;
    check_all();
  endtask

  task automatic wr(input logic [13:0] a, input logic [7:0] d);
    busAddr = a; busDataIn = d; busWrite = 1; tick(); busWrite = 0;
  endtask

  task automatic rd(input logic [13:0] a);
    busAddr = a; busRead = 1; tick(); busRead = 0;
  endtask

  task automatic reset_checks();
    chk("rst_busDataOut", busDataOut, 8'h00);
    chk("rst_streamData", streamData, 8'h00);
    chk("rst_irq", irq, 1'b0);
    chk("rst_initBusy", initBusy, 1'b0);
    chk("rst_regMax", regMax, '0);
    chk("rst_run", regCtrlRun, '0);
  endtask

  task automatic do_reset();
    busReset = 1;
    #1;
    reset_checks();
    model_reset();
    repeat (2) @(posedge busClk);
    #1;
    busReset = 0;
    check_all();
  endtask

  task automatic rand_cycles(input int n);
    int k;
    for (int i = 0; i < n; i++) begin
      busWrite = 0; busRead = 0;
      syncStart = ($urandom_range(0, 15) == 0) ? CH'($urandom) : '0;
      streamSyncOf = ($urandom_range(0, 15) == 0) ? CH'($urandom) : '0;
      state = CH'($urandom);
      streamAddr = 6'($urandom);
      busDataIn = 8'($urandom);
      k = $urandom_range(0, 9);
      if (k < 4)
        busAddr = {1'b0, 7'($urandom), 6'($urandom_range(0, 63))};
      else if (k < 7)
        busAddr = {2'b10, 8'($urandom), 1'($urandom), 3'($urandom)};
      else
        busAddr = {2'b11, 10'($urandom), 2'($urandom)};
      if (busAddr[13:12] == 2'b11 && busAddr[1:0] == 2'd0 &&
          $urandom_range(0, 7) != 0)
        busDataIn[0] = 1'b0;
      k = $urandom_range(0, 99);
      if (k < 40) busWrite = 1;
      else if (k < 70) busRead = 1;
      tick();
    end
    busWrite = 0; busRead = 0; syncStart = '0; streamSyncOf = '0;
  endtask

  initial begin
    int n;
    busReset = 1; busAddr = '0; busDataIn = '0; busWrite = 0;
    busRead = 0; streamAddr = '0; syncStart = '0; streamSyncOf = '0;
    state = '0;
    do_reset();

    wr(14'd5, 8'hA5);
    rd(14'd5);
    chk("rd_idx5", busDataOut, 8'hA5);
    streamAddr = 6'd5;
    wr(GCTRL, 8'h02);
    rd(STATUS);
    chk("status_after_swap", busDataOut, 8'h00);
    chk("stream_after_swap", streamData, 8'hA5);

    wr(14'h200A, 8'h04);
    syncStart = 2'b10; tick(); syncStart = '0;
    chk("ch1_run_start", regCtrlRun[1], 1'b1);
    streamSyncOf = 2'b10; tick(); streamSyncOf = '0;
    chk("ch1_run_loop", regCtrlRun[1], 1'b1);
    rd(FLAGS);
    chk("frameDone1", busDataOut[2], 1'b1);
    wr(14'h200A, 8'h02);
    streamSyncOf = 2'b10; tick(); streamSyncOf = '0;
    chk("ch1_run_noloop", regCtrlRun[1], 1'b0);
    syncStart = 2'b10; streamSyncOf = 2'b10; tick();
    syncStart = '0; streamSyncOf = '0;
    chk("ch1_start_wins", regCtrlRun[1], 1'b1);

    wr(14'h2001, 8'hFF);
    chk("max0_high", regMax[12:8], 5'h1F);
    wr(IEN, 8'h01);
    wr(GCTRL, 8'h01);
    n = 0;
    while (initBusy && n < 200) begin
      n++;
      tick();
    end
    chk("initBusy_cycles", n, 64);
    rd(14'd5);
    chk("clr_pix5", busDataOut, 8'h00);
    rd(14'd63);
    chk("clr_pix63", busDataOut, 8'h00);
    rd(14'h2002);
    chk("clr_ctrl0", busDataOut, 8'h00);
    rd(14'h200A);
    chk("clr_ctrl1", busDataOut, 8'h00);
    chk("irq_initDone", irq, 1'b1);
    wr(FLAGS, 8'h01);
    chk("irq_cleared", irq, 1'b0);

    wr(14'h2002, 8'h02);
    wr(14'd7, 8'h3C);
    streamAddr = 6'd7;
    wr(GCTRL, 8'h02);
    rd(STATUS);
    chk("swap_pending", busDataOut, 8'h02);
    repeat (3) tick();
    streamSyncOf = 2'b01; tick(); streamSyncOf = '0;
    rd(STATUS);
    chk("swap_done", busDataOut, 8'h00);
    chk("swap_stream", streamData, 8'h3C);

    rand_cycles(400);

    wr(GCTRL, 8'h01);
    repeat (10) tick();
    chk("busy_mid_clear", initBusy, 1'b1);
    #2;
    do_reset();
    rand_cycles(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
